cdb_writeback_arbiter: RTL and testbench
========================================

// Module: cdb_writeback_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) between the ALU, branch and LSU
//  functional units.
//  Each unit pushes completed results (ROB tag + value) into a small per-unit
//  FIFO. A round-robin scheduler grants one FIFO head per cycle onto a
//  registered CDB, which feeds the ROB, PRF write port and RS wakeup.
//  Absorbs writeback collisions so no functional unit result is ever dropped.
// PARAMETERS
//  N_REQ      3   number of requesters (0=ALU, 1=BR, 2=LSU)
//  DATA_W     32  result data width
//  TAG_W      5   ROB tag width
//  PREG_W     7   physical destination register width
//  BUF_DEPTH  2   entries per requester FIFO (power of 2, >=2)
// PORTS
//  clk        in   1               clock, all state on rising edge
//  rst        in   1               reset, synchronous, active-low
//  flush      in   1               mispredict flush, discard all buffered results
//  req_valid  in   N_REQ           requester i has a result
//  req_ready  out  N_REQ           requester i FIFO can accept
//  req_tag    in   N_REQ*TAG_W     ROB tag, slice i = [i*TAG_W +: TAG_W]
//  req_preg   in   N_REQ*PREG_W    destination phys reg (0 = no write)
//  req_data   in   N_REQ*DATA_W    result value
//  cdb_valid  out  1               CDB broadcast valid
//  cdb_tag    out  TAG_W           broadcast ROB tag
//  cdb_preg   out  PREG_W          broadcast phys reg
//  cdb_data   out  DATA_W          broadcast value
//  cdb_src    out  $clog2(N_REQ)   index of granted requester
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): FIFOs empty; rr_ptr=0.
//    cdb_valid, cdb_tag, cdb_preg, cdb_data and cdb_src are all 0.
//    req_ready is held 0 while rst==0. It is 1 in the first cycle after reset release.
//  - req_ready[i] = (count[i] != BUF_DEPTH), derived from registered count only.
//  - Push: req_valid[i] && req_ready[i] at the edge writes {tag,preg,data} into FIFO i.
//    req_valid while not ready is ignored; the requester must hold it.
//  - Arbitration (combinational, each cycle): scan i = rr_ptr, rr_ptr+1, ... mod N_REQ.
//    Grant the first non-empty FIFO. No grant if all FIFOs are empty.
//  - On a grant to g at an edge: pop FIFO g.
//    cdb_* is registered from its head with cdb_valid=1 and cdb_src=g.
//    rr_ptr becomes (g+1) mod N_REQ, wrapping N_REQ-1 -> 0.
//  - No grant: cdb_valid=0, cdb_tag/preg/data/src=0, and rr_ptr holds.
//  - Latency: a result pushed at edge E is broadcast earliest at edge E+1.
//    It is visible the cycle after E+1. There is no combinational bypass from req_* to cdb_*.
//  - Simultaneous push and pop on the same FIFO is legal.
//    The count is unchanged and the FIFO ordering is preserved.
//  - Full FIFO: req_ready=0 for that cycle.
//    A pop in the same cycle does NOT raise ready until the next cycle.
//  - Fairness: with K non-empty FIFOs, each is granted within K cycles.
//    Worst-case wait for a FIFO head is N_REQ-1 cycles.
//  - Flush (rst==1, flush==1 at edge): all FIFOs emptied and any same-cycle push discarded.
//    cdb_valid=0 next cycle. rr_ptr unchanged.
//  - Reset has priority over flush. Reset mid-burst drops all entries.
//  - Per-FIFO counters are $clog2(BUF_DEPTH)+1 bits. Read/write pointers wrap modulo BUF_DEPTH.
// TESTING
//  1 Reset: drive rst=0 for 3 edges with req_valid=3'b111.
//    Required: req_ready=0 and cdb_valid=0 throughout.
//    After release: req_ready=3'b111 and no push has occurred.
//  2 Single: ALU pushes tag=5, preg=12, data=0xDEADBEEF at edge E.
//    Required: after E+1, cdb_valid=1, tag=5, preg=12, data=0xDEADBEEF, src=0.
//    After E+2: cdb_valid=0.
//  3 Collision: all three push at edge E (tags 1,2,3), rr_ptr=0.
//    Required: CDB tags 1,2,3 after edges E+1,E+2,E+3, then rr_ptr=0.
//  4 Full/backpressure: LSU pushes every cycle while ALU and BR push continuously.
//    Required: LSU ready drops to 0 when count=2.
//    No entry is lost or duplicated, and per-source order is preserved (scoreboard).
//  5 Flush: load 2 entries per FIFO, assert flush for 1 cycle alongside a new push.
//    Required: cdb_valid=0 next cycle, all ready=1, and the pushed entry is never broadcast.
//  6 Fairness: ALU and LSU saturate for 100 cycles, BR idle.
//    Required: grants strictly alternate 0,2,0,2; no source waits more than 2 cycles.

Source files
------------

// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter: per-unit result FIFOs round-robin arbitrated onto a registered CDB
module cdb_writeback_arbiter #(
  parameter int N_REQ     = 3,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 5,
  parameter int PREG_W    = 7,
  parameter int BUF_DEPTH = 2,
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*TAG_W-1:0]   req_tag_i,
  input  logic [N_REQ*PREG_W-1:0]  req_preg_i,
  input  logic [N_REQ*DATA_W-1:0]  req_data_i,
  output logic                     cdb_valid_o,
  output logic [TAG_W-1:0]         cdb_tag_o,
  output logic [PREG_W-1:0]        cdb_preg_o,
  output logic [DATA_W-1:0]        cdb_data_o,
  output logic [SRC_W-1:0]         cdb_src_o
);
  localparam int ENT_W = TAG_W + PREG_W + DATA_W;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [ENT_W-1:0] mem_q [N_REQ][BUF_DEPTH];
  logic [PTR_W-1:0] rd_q [N_REQ];
  logic [PTR_W-1:0] wr_q [N_REQ];
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [SRC_W-1:0] rr_q;
  logic [ENT_W-1:0] ent [N_REQ];
  logic [N_REQ-1:0] ne, push, pop;
  logic [SRC_W-1:0] gnt;
  logic             gnt_v;
  logic [ENT_W-1:0] head;
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ent[i] = {req_tag_i[i*TAG_W +: TAG_W], req_preg_i[i*PREG_W +: PREG_W], req_data_i[i*DATA_W +: DATA_W]};
      ne[i] = cnt_q[i] != '0;
      req_ready_o[i] = rst && (cnt_q[i] != CNT_W'(BUF_DEPTH));
    end
  end
  // Scan downward so the last hit is the closest requester at or after rr_q.
  always_comb begin
    gnt = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (ne[(int'(rr_q) + k) % N_REQ]) gnt = SRC_W'((int'(rr_q) + k) % N_REQ);
    gnt_v = |ne;
    head = mem_q[gnt][rd_q[gnt]];
    for (int i = 0; i < N_REQ; i++) begin
      push[i] = req_valid_i[i] && req_ready_o[i] && !flush_i;
      pop[i] = gnt_v && !flush_i && (gnt == SRC_W'(i));
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q        <= '0;
      cdb_valid_o <= 1'b0;
      cdb_tag_o   <= '0;
      cdb_preg_o  <= '0;
      cdb_data_o  <= '0;
      cdb_src_o   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      cdb_valid_o <= gnt_v && !flush_i;
      {cdb_tag_o, cdb_preg_o, cdb_data_o} <= (gnt_v && !flush_i) ? head : '0;
      cdb_src_o   <= (gnt_v && !flush_i) ? gnt : '0;
      if (gnt_v && !flush_i) rr_q <= (gnt == SRC_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (flush_i) begin
          rd_q[i]  <= '0;
          wr_q[i]  <= '0;
          cnt_q[i] <= '0;
        end else begin
          if (push[i]) mem_q[i][wr_q[i]] <= ent[i];
          if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
          if (pop[i]) rd_q[i] <= rd_q[i] + 1'b1;
          cnt_q[i] <= cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// tb_cdb_writeback_arbiter: directed plus random stimulus against a queue-based CDB model
module tb_cdb_writeback_arbiter;
  localparam int D = 2;
  typedef logic [43:0] ent_t;
  logic        clk = 0, rst = 0, flush = 0;
  logic [2:0]  vld = 0, rdy;
  logic [14:0] tag = 0;
  logic [20:0] preg = 0;
  logic [95:0] data = 0;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [6:0]  cdb_preg;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  ent_t        q [3][$];
  int          rr;
  logic        ev;
  ent_t        eent;
  logic [1:0]  esrc;
  logic [2:0]  acc;
  int          n_vec, n_err;
  cdb_writeback_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(vld), .req_ready_o(rdy),
    .req_tag_i(tag), .req_preg_i(preg), .req_data_i(data),
    .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag), .cdb_preg_o(cdb_preg),
    .cdb_data_o(cdb_data), .cdb_src_o(cdb_src)
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  function automatic logic [2:0] exp_rdy();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = rst && (q[i].size() != D);
    return r;
  endfunction
  task automatic model_edge();
    logic [2:0] r;
    int g;
    r = exp_rdy();
    acc = '0;
    if (!rst) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      rr = 0; ev = 0; eent = '0; esrc = '0;
      return;
    end
    g = -1;
    for (int k = 0; k < 3; k++)
      if (g < 0 && q[(rr + k) % 3].size() > 0) g = (rr + k) % 3;
    if (flush) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      ev = 0; eent = '0; esrc = '0;
      return;
    end
    if (g >= 0) begin
      ev = 1; eent = q[g].pop_front(); esrc = 2'(g); rr = (g + 1) % 3;
    end else begin
      ev = 0; eent = '0; esrc = '0;
    end
    for (int i = 0; i < 3; i++)
      if (vld[i] && r[i]) begin
        q[i].push_back({tag[i*5 +: 5], preg[i*7 +: 7], data[i*32 +: 32]});
        acc[i] = 1;
      end
  endtask
  task automatic set_src(input int i, input logic [4:0] t, input logic [6:0] p, input logic [31:0] d);
    tag[i*5 +: 5] = t;
    preg[i*7 +: 7] = p;
    data[i*32 +: 32] = d;
  endtask
  task automatic step(input logic r, input logic f, input logic [2:0] v);
    rst = r; flush = f; vld = v;
    #1;
    chk("ready", rdy, exp_rdy());
    @(posedge clk);
    model_edge();
    #1;
    chk("cdb", {cdb_valid, cdb_tag, cdb_preg, cdb_data, cdb_src}, {ev, eent, esrc});
  endtask
  // Refresh payload on sources whose last offer was taken; others keep holding.
  task automatic refresh(input logic [2:0] want, output logic [2:0] v);
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && !acc[i] && want[i]) v[i] = 1;
      else begin
        v[i] = want[i];
        set_src(i, 5'($urandom), 7'($urandom), $urandom);
      end
    end
  endtask
  initial begin
    logic [2:0] v;
    int saw_full, n0, n2;
    acc = '0;
    @(posedge clk); #1;
    // reset with all requesters asserting
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 3'b111);
      chk("rst_valid", cdb_valid, 0);
    end
    vld = 0; rst = 1; #1;
    chk("rel_ready", rdy, 3'b111);
    step(1, 0, 3'b000);
    chk("rel_nopush", cdb_valid, 0);
    // single ALU result
    set_src(0, 5, 12, 32'hDEADBEEF);
    step(1, 0, 3'b001);
    step(1, 0, 3'b000);
    chk("t2", {cdb_valid, cdb_tag, cdb_preg, cdb_data, cdb_src}, {1'b1, 5'd5, 7'd12, 32'hDEADBEEF, 2'd0});
    step(1, 0, 3'b000);
    chk("t2_idle", cdb_valid, 0);
    // collision after reset so rr starts at 0
    step(0, 0, 3'b000);
    for (int i = 0; i < 3; i++) set_src(i, 5'(i + 1), 7'(i + 20), 32'(i * 100));
    step(1, 0, 3'b111);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 3'b000);
      chk("t3_tag", {cdb_valid, cdb_tag, cdb_src}, {1'b1, 5'(i + 1), 2'(i)});
    end
    step(1, 0, 3'b000);
    chk("t3_done", cdb_valid, 0);
    // rr back at 0: BR and ALU together -> ALU first
    set_src(0, 9, 1, 1); set_src(1, 10, 2, 2);
    step(1, 0, 3'b011);
    step(1, 0, 3'b000);
    chk("t3_rr", {cdb_tag, cdb_src}, {5'd9, 2'd0});
    step(1, 0, 3'b000);
    // backpressure with all sources saturating
    saw_full = 0;
    acc = '0; vld = 0;
    for (int c = 0; c < 30; c++) begin
      refresh(3'b111, v);
      step(1, 0, v);
      if (rdy[2] === 1'b0) saw_full = 1;
    end
    chk("t4_full", saw_full, 1);
    for (int c = 0; c < 8; c++) step(1, 0, 3'b000);
    // flush with a same-cycle push
    for (int c = 0; c < 6; c++) begin
      refresh(3'b111, v);
      step(1, 0, v);
    end
    for (int i = 0; i < 3; i++) set_src(i, 5'(i + 28), 7'h7F, 32'hBAD0_0000 + i);
    step(1, 1, 3'b111);
    chk("t5_valid", cdb_valid, 0);
    vld = 0; flush = 0; #1;
    chk("t5_ready", rdy, 3'b111);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 3'b000);
      chk("t5_drop", cdb_valid, 0);
    end
    // fairness: ALU and LSU saturate, BR idle
    n0 = 0; n2 = 0; acc = '0;
    for (int c = 0; c < 100; c++) begin
      refresh(3'b101, v);
      step(1, 0, v);
      if (cdb_valid && cdb_src == 0) n0++;
      if (cdb_valid && cdb_src == 2) n2++;
    end
    chk("t6_bal", (n0 - n2 <= 1 && n2 - n0 <= 1 && n0 + n2 >= 98), 1);
    for (int c = 0; c < 6; c++) step(1, 0, 3'b000);
    // random traffic with occasional flush and reset
    acc = '0;
    for (int c = 0; c < 400; c++) begin
      refresh(3'($urandom), v);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 24) == 0), v);
    end
    for (int c = 0; c < 8; c++) step(1, 0, 3'b000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
